// File: rtl/raycast_pkg.sv
// Shared types for the raycaster column packet path:
// packet field layout, FIFO entry and TX state encoding.
package raycast_pkg;

  localparam int HC_W  = 9;
  localparam int LH_W  = 8;
  localparam int MAP_W = 4;
  localparam int WX_W  = 16;
  localparam int PKT_W = HC_W + LH_W + 1 + MAP_W + WX_W;

  localparam int HC_LSB  = 29;
  localparam int LH_LSB  = 21;
  localparam int WT_BIT  = 20;
  localparam int MAP_LSB = 16;
  localparam int WX_LSB  = 0;

  typedef struct packed {
    logic [HC_W-1:0]  hcount;
    logic [LH_W-1:0]  line_h;
    logic             wall_type;
    logic [MAP_W-1:0] map_data;
    logic [WX_W-1:0]  wall_x;
  } dda_packet_t;

  typedef struct packed {
    logic        last;
    dda_packet_t pkt;
  } tx_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } tx_state_t;

  function automatic logic [LH_W-1:0] clamp_height(
    input logic [15:0] lh,
    input logic [15:0] max_h
  );
    return (lh > max_h) ? max_h[LH_W-1:0] : lh[LH_W-1:0];
  endfunction

endpackage

// File: rtl/dda_tx_fifo.sv
// Small synchronous FIFO holding column packets plus their
// end-of-frame flag; head entry is presented combinationally.
module dda_tx_fifo
  import raycast_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  tx_entry_t din,
  input  logic      pop,
  output tx_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  tx_entry_t     mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case (1'b1)
        do_push && !do_pop: count <= count + 1'b1;
        do_pop && !do_push: count <= count - 1'b1;
        default:            count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/dda_packet_tx.sv
// Packs DDA column results into AXI-stream beats, one frame
// sweep per frame_start, with sticky overflow/sequence flags.
module dda_packet_tx
  import raycast_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180,
  parameter int DEPTH         = 4
) (
  input  logic             pixel_clk_in,
  input  logic             rst_n_in,
  input  logic             frame_start_in,
  input  logic             dda_valid_in,
  input  logic [HC_W-1:0]  hcount_ray_in,
  input  logic [15:0]      lineHeight_in,
  input  logic             wallType_in,
  input  logic [MAP_W-1:0] mapData_in,
  input  logic [WX_W-1:0]  wallX_in,
  output logic             dda_ready_out,
  output logic             tx_axis_tvalid_out,
  input  logic             tx_axis_tready_in,
  output logic [PKT_W-1:0] tx_axis_tdata_out,
  output logic             tx_axis_tlast_out,
  output logic             frame_done_out,
  output logic             overflow_err_out,
  output logic             seq_err_out
);

  localparam logic [HC_W-1:0] LAST_COL = HC_W'(SCREEN_WIDTH - 1);
  localparam logic [15:0]     MAX_H    = 16'(SCREEN_HEIGHT);

  tx_state_t       state;
  tx_state_t       state_nxt;
  logic            arm_ok;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            drop;
  logic            start;
  logic            done;
  logic [HC_W-1:0] exp_col;
  tx_entry_t       entry;
  tx_entry_t       head;

  // Gates frame_start until one edge after reset release.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) arm_ok <= 1'b0;
    else           arm_ok <= 1'b1;
  end

  assign dda_ready_out = (state == STREAM) && !full;
  assign push  = dda_valid_in && dda_ready_out;
  assign drop  = dda_valid_in && !dda_ready_out;
  assign start = (state == IDLE) && frame_start_in && arm_ok;
  assign pop   = !empty && tx_axis_tready_in;
  assign done  = (state == DRAIN) && pop && head.last;

  always_comb begin
    entry               = '0;
    entry.last          = (hcount_ray_in == LAST_COL);
    entry.pkt.hcount    = hcount_ray_in;
    entry.pkt.line_h    = clamp_height(lineHeight_in, MAX_H);
    entry.pkt.wall_type = wallType_in;
    entry.pkt.map_data  = mapData_in;
    entry.pkt.wall_x    = wallX_in;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (push && entry.last) state_nxt = DRAIN;
      DRAIN:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      exp_col          <= '0;
      frame_done_out   <= 1'b0;
      overflow_err_out <= 1'b0;
      seq_err_out      <= 1'b0;
    end else begin
      state          <= state_nxt;
      frame_done_out <= done;
      if (start)     exp_col <= '0;
      else if (push) exp_col <= exp_col + 1'b1;
      overflow_err_out <= (overflow_err_out && !start) || drop;
      seq_err_out      <= (seq_err_out && !start)
                       || (push && (hcount_ray_in != exp_col));
    end
  end

  dda_tx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (pixel_clk_in),
    .rst_n (rst_n_in),
    .push  (push),
    .din   (entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign tx_axis_tvalid_out = !empty;
  assign tx_axis_tlast_out  = !empty && head.last;

  always_comb begin
    tx_axis_tdata_out = '0;
    if (!empty) begin
      tx_axis_tdata_out[HC_LSB +: HC_W]   = head.pkt.hcount;
      tx_axis_tdata_out[LH_LSB +: LH_W]   = head.pkt.line_h;
      tx_axis_tdata_out[WT_BIT]           = head.pkt.wall_type;
      tx_axis_tdata_out[MAP_LSB +: MAP_W] = head.pkt.map_data;
      tx_axis_tdata_out[WX_LSB +: WX_W]   = head.pkt.wall_x;
    end
  end

endmodule

// File: doc/dda_packet_tx.md
DDA_PACKET_TX -- requirements
Module: dda_packet_tx

Interface
REQ-001 Parameter SCREEN_WIDTH, default 320: columns per frame; last column index is SCREEN_WIDTH-1.
REQ-002 Parameter SCREEN_HEIGHT, default 180: maximum emitted line height.
REQ-003 Parameter DEPTH, default 4: entries in the internal column buffer (power of two, >=2).
REQ-004 Clocking: one clock, pixel_clk_in; reset is asynchronous and active-low, rst_n_in.
REQ-005 Ports (name  direction  width  meaning):
- pixel_clk_in  in  1  clock
- rst_n_in  in  1  async active-low reset
- frame_start_in  in  1  single-cycle pulse that arms a new frame sweep
- dda_valid_in  in  1  column result valid from DDA core
- hcount_ray_in  in  9  column index
- lineHeight_in  in  16  unclamped wall line height
- wallType_in  in  1  0 = X wall hit, 1 = Y wall hit
- mapData_in  in  4  map cell value
- wallX_in  in  16  wall hit fraction
- dda_ready_out  out  1  block can accept a column this cycle
- tx_axis_tvalid_out  out  1  AXI-stream valid toward DDA-out FIFO
- tx_axis_tready_in  in  1  AXI-stream ready from FIFO
- tx_axis_tdata_out  out  38  packed column packet
- tx_axis_tlast_out  out  1  marks last column of frame
- frame_done_out  out  1  one-cycle pulse when the tlast beat handshakes
- overflow_err_out  out  1  sticky: column presented while not ready
- seq_err_out  out  1  sticky: hcount_ray_in differs from expected column

Function
REQ-006 Packet layout: [37:29] hcount, [28:21] clamped line height, [20] wallType, [19:16] mapData, [15:0] wallX.
REQ-007 Clamp: line height field = min(lineHeight_in, SCREEN_HEIGHT), 8 bits, unsigned compare on full 16 bits.
REQ-008 States: IDLE, STREAM, DRAIN.
REQ-009 IDLE: dda_ready_out=0; frame_start_in -> STREAM, expected column counter := 0, both sticky errors cleared.
REQ-010 STREAM: dda_ready_out = buffer not full; a column is accepted when dda_valid_in && dda_ready_out.
REQ-011 Accepted column written to buffer with tlast bit = (hcount_ray_in == SCREEN_WIDTH-1); expected counter increments.
REQ-012 Accepting the column with tlast bit set -> DRAIN in the next cycle; dda_ready_out=0 from that cycle onward.
REQ-013 DRAIN: no new columns; once the tlast beat handshakes, frame_done_out pulses that same cycle's next edge (one cycle) and state -> IDLE.
REQ-014 frame_start_in outside IDLE is ignored.
REQ-015 Latency: column accepted at edge N appears on tx_axis_* with tvalid at N+1 when the buffer was empty.
REQ-016 tx_axis_tvalid_out = buffer not empty; tdata/tlast driven from buffer head; head advances only on tvalid && tready.
REQ-017 Once asserted, tvalid and tdata/tlast stay stable until handshake.
REQ-018 Full buffer: push and pop in same cycle impossible (ready low when full); pop frees one entry, ready rises next cycle.
REQ-019 Empty buffer with simultaneous push: no pass-through; pushed beat visible next cycle.
REQ-020 Pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
REQ-021 dda_valid_in while dda_ready_out=0 (any state): column dropped, overflow_err_out set.
REQ-022 Accepted column with hcount_ray_in != expected counter: seq_err_out set, column still forwarded unmodified (apart from clamp), tlast still decided by hcount_ray_in.

Reset
REQ-023 While rst_n_in low: state IDLE, buffer empty, pointers/counters 0, dda_ready_out=0, tx_axis_tvalid_out=0, tx_axis_tdata_out=0, tx_axis_tlast_out=0, frame_done_out=0, both error flags 0.
REQ-024 Reset asserted mid-frame discards all buffered columns immediately; no partial packet is emitted after release.
REQ-025 Reset deassertion is synchronised internally; first frame_start_in honoured from second edge after release.

Structure
REQ-026 Shared package raycast_pkg holds packet field offsets/widths, packed struct dda_packet_t (38 bits) and the tx state enum.
REQ-027 One sub-module, dda_tx_fifo: DEPTH-entry synchronous FIFO of {tlast, dda_packet_t} with full/empty.

Verification
REQ-028 Reset, frame_start, 320 columns hcount 0..319, tready=1 always -> 320 beats in order, tlast only on hcount 319, frame_done_out one pulse, state IDLE.
REQ-029 lineHeight_in=0x0400 on hcount 5 -> tdata[28:21]=180; lineHeight_in=40 -> 40.
REQ-030 tready=0 for 10 cycles, DEPTH=4 -> exactly 4 columns accepted, dda_ready_out=0; 5th valid sets overflow_err_out; tready=1 -> ready rises one cycle after first pop.
REQ-031 hcount sequence 0,1,3 -> seq_err_out=1 after third acceptance; third beat carries hcount 3.
REQ-032 rst_n_in low for 1 cycle after 100 columns with 3 buffered -> tvalid=0 immediately, no further beats until new frame_start.
REQ-033 frame_start_in pulsed during STREAM at column 50 -> ignored; frame completes normally at 319.
